rat_rename_stage: RTL and testbench
===================================

# rat_rename_stage

Single-thread register alias table (RAT) and rename stage that sits directly upstream of the physical register file (`prf`). Each cycle it accepts one decoded instruction, translates its two source architectural registers to PRF indices, requests a new PRF entry for the destination over the `rat_allocate_new_prf` handshake, and presents the renamed instruction one cycle later. On a branch mispredict it restores its map from the RRAT and reports its speculative mappings to the PRF for freeing.

## Interface
- `ARCH_REG_NUM`, 32, number of architectural registers.
- `PRF_SIZE`, 64, number of PRF entries; `IDX_W = $clog2(PRF_SIZE)`.
- `clock` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `inst_valid` in 1: decoded instruction present.
- `inst_opa_arch_idx`, `inst_opb_arch_idx`, `inst_dest_arch_idx` in 5: architectural operands.
- `inst_dest_valid` in 1: instruction writes a destination.
- `rename_stall` out 1: combinational; instruction not accepted this cycle.
- `rat_allocate_new_prf` out 1: combinational PRF allocation request.
- `prf_rename_valid_in` in 1: PRF granted an entry this cycle.
- `prf_rename_idx_in` in IDX_W: granted entry index.
- `rename_out_valid` out 1: registered; renamed instruction valid.
- `opa_prf_idx`, `opb_prf_idx`, `dest_prf_idx` out IDX_W: registered renamed indices.
- `branch_mistaken` in 1: mispredict recovery request.
- `rrat_arch_table` in ARCH_REG_NUM*IDX_W: RRAT map, entry i at bits [i*IDX_W +: IDX_W].
- `rat_prf_free_list` out PRF_SIZE: registered bitmap of speculative mappings.
- `rat_free_list_valid` out 1: registered; `rat_prf_free_list` meaningful.

## Operation
- States: NORMAL, RECOVER. Reset → NORMAL.
- Reset: map[i] = i for all i; `rename_out_valid`, `rat_free_list_valid` = 0; all index outputs and `rat_prf_free_list` = 0.
- Allocation needed = `inst_valid & inst_dest_valid` (and dest ≠ 31 when zero-reg feature enabled).
- NORMAL, not `branch_mistaken`: `rat_allocate_new_prf` = allocation needed. `rename_stall` = allocation needed & !`prf_rename_valid_in`.
- Accept = `inst_valid & !rename_stall`. On accept: opa/opb indices latched from map as it was before this edge (opa == dest returns old mapping); `dest_prf_idx` = `prf_rename_idx_in` if allocated else 0; map[dest] ← `prf_rename_idx_in` if allocated; `rename_out_valid` ← 1. Otherwise `rename_out_valid` ← 0, map unchanged.
- `branch_mistaken` (any state): `rat_allocate_new_prf` = 0, `rename_stall` = 1, instruction dropped. At edge: `rat_prf_free_list` ← bitmap with bit map[i] set for every i (pre-copy map); map ← `rrat_arch_table`; `rat_free_list_valid` ← 1; state → RECOVER; `rename_out_valid` ← 0.
- RECOVER: `rename_stall` = 1, no allocation; next edge → NORMAL, `rat_free_list_valid` ← 0. `branch_mistaken` again in RECOVER repeats recovery, stays RECOVER.
- Reset has priority over all; reset mid-RECOVER returns to NORMAL with identity map.

## Timing
- Lookup/allocation handshake combinational in cycle N; renamed outputs valid cycle N+1 (latency 1); throughput 1 instr/cycle.
- Instruction at N+1 sees map updated by instruction at N; no intra-cycle bypass needed.
- PRF grant with `rat_allocate_new_prf` = 0 is ignored.
- Recovery: mispredict at N → free list valid N+1 only → first accept possible N+2.
- Stall holds upstream; upstream must keep instruction stable while `rename_stall` = 1.

## Configuration
- `RAT_ZERO_REG_EN` defined: arch reg 31 never renamed; dest 31 requests no allocation and leaves map[31] = 31; sources 31 always return 31; map[31] excluded from `rat_prf_free_list` and RRAT copy.
- Undefined: reg 31 treated like any other register.

## Test plan
- Reset then instr opa=1, opb=2, dest=3, PRF grants 40 → next cycle out_valid=1, opa=1, opb=2, dest=40; following instr opa=3 → opa=40.
- Instr dest=5, opa=5, grant 41 → opa=5 (old), dest=41; map[5]=41 afterwards.
- Allocation request with `prf_rename_valid_in`=0 for 2 cycles → `rename_stall`=1, out_valid=0, map unchanged; grant 42 third cycle → accepted.
- After renaming r3→40, r4→41, `branch_mistaken` with RRAT identity → next cycle free_list_valid=1, bits 40,41 and identity bits set, bit 3/4 clear; stall; cycle after, instr opa=3 → opa=3.
- With `RAT_ZERO_REG_EN`: dest=31 → `rat_allocate_new_prf`=0, out_valid=1, dest=0, map[31]=31; without: grant 50, map[31]=50.
- Reset low during RECOVER → next cycle NORMAL, all outputs 0, map identity.

Source files
------------

// File: rtl/rat_rename_stage.sv
// Register alias table and rename stage; RAT_ZERO_REG_EN pins arch reg 31 to PRF 31. Latency 1, 1 instr/cycle.
// Backpressure: rename_stall holds upstream while a PRF grant is missing or a mispredict recovery is in flight.
module rat_rename_stage #(
  parameter int ARCH_REG_NUM = 32,
  parameter int PRF_SIZE     = 64,
  parameter int IDX_W        = $clog2(PRF_SIZE)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          inst_valid,
  input  logic [4:0]                    inst_opa_arch_idx,
  input  logic [4:0]                    inst_opb_arch_idx,
  input  logic [4:0]                    inst_dest_arch_idx,
  input  logic                          inst_dest_valid,
  output logic                          rename_stall,
  output logic                          rat_allocate_new_prf,
  input  logic                          prf_rename_valid_in,
  input  logic [IDX_W-1:0]              prf_rename_idx_in,
  output logic                          rename_out_valid,
  output logic [IDX_W-1:0]              opa_prf_idx,
  output logic [IDX_W-1:0]              opb_prf_idx,
  output logic [IDX_W-1:0]              dest_prf_idx,
  input  logic                          branch_mistaken,
  input  logic [ARCH_REG_NUM*IDX_W-1:0] rrat_arch_table,
  output logic [PRF_SIZE-1:0]           rat_prf_free_list,
  output logic                          rat_free_list_valid
);

  typedef enum logic {NORMAL, RECOVER} state_t;

  localparam int ZERO_REG = 31;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] map [ARCH_REG_NUM];
  logic             alloc_need;
  logic             accept;
  logic             allocated;
  logic [IDX_W-1:0] opa_lookup, opb_lookup;
  logic [PRF_SIZE-1:0] free_bits;

`ifdef RAT_ZERO_REG_EN
  assign alloc_need = inst_valid & inst_dest_valid & (inst_dest_arch_idx != 5'(ZERO_REG));
  assign opa_lookup = (inst_opa_arch_idx == 5'(ZERO_REG)) ? IDX_W'(ZERO_REG) : map[inst_opa_arch_idx];
  assign opb_lookup = (inst_opb_arch_idx == 5'(ZERO_REG)) ? IDX_W'(ZERO_REG) : map[inst_opb_arch_idx];
`else
  assign alloc_need = inst_valid & inst_dest_valid;
  assign opa_lookup = map[inst_opa_arch_idx];
  assign opb_lookup = map[inst_opb_arch_idx];
`endif

  always_comb begin
    state_nxt            = state;
    rat_allocate_new_prf = 1'b0;
    rename_stall         = 1'b0;
    if (branch_mistaken) begin
      rename_stall = 1'b1;
      state_nxt    = RECOVER;
    end else begin
      case (state)
        NORMAL: begin
          rat_allocate_new_prf = alloc_need;
          rename_stall         = alloc_need & ~prf_rename_valid_in;
        end
        RECOVER: begin
          rename_stall = 1'b1;
          state_nxt    = NORMAL;
        end
        default: state_nxt = NORMAL;
      endcase
    end
  end

  assign accept    = inst_valid & ~rename_stall;
  assign allocated = rat_allocate_new_prf & prf_rename_valid_in;

  // Every PRF entry currently named by the speculative map is reported for freeing.
  always_comb begin
    free_bits = '0;
    for (int i = 0; i < ARCH_REG_NUM; i++) begin
`ifdef RAT_ZERO_REG_EN
      if (i != ZERO_REG) free_bits[map[i]] = 1'b1;
`else
      free_bits[map[i]] = 1'b1;
`endif
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state               <= NORMAL;
      rename_out_valid    <= 1'b0;
      rat_free_list_valid <= 1'b0;
      opa_prf_idx         <= '0;
      opb_prf_idx         <= '0;
      dest_prf_idx        <= '0;
      rat_prf_free_list   <= '0;
      for (int i = 0; i < ARCH_REG_NUM; i++) map[i] <= IDX_W'(i);
    end else begin
      state <= state_nxt;
      if (branch_mistaken) begin
        rat_prf_free_list   <= free_bits;
        rat_free_list_valid <= 1'b1;
        rename_out_valid    <= 1'b0;
        for (int i = 0; i < ARCH_REG_NUM; i++) begin
`ifdef RAT_ZERO_REG_EN
          if (i != ZERO_REG) map[i] <= rrat_arch_table[i*IDX_W +: IDX_W];
`else
          map[i] <= rrat_arch_table[i*IDX_W +: IDX_W];
`endif
        end
      end else begin
        rat_free_list_valid <= 1'b0;
        rename_out_valid    <= accept;
        if (accept) begin
          opa_prf_idx  <= opa_lookup;
          opb_prf_idx  <= opb_lookup;
          dest_prf_idx <= allocated ? prf_rename_idx_in : '0;
        end
        if (allocated) map[inst_dest_arch_idx] <= prf_rename_idx_in;
      end
    end
  end

endmodule

// File: tb/tb_rat_rename_stage.sv
// Directed test-plan steps followed by randomized traffic, checked against an array-based rename model.
module tb_rat_rename_stage;

  localparam int ARCH = 32;
  localparam int PRF  = 64;
  localparam int W    = 6;

  logic            clock = 1'b0;
  logic            reset;
  logic            inst_valid;
  logic [4:0]      inst_opa_arch_idx, inst_opb_arch_idx, inst_dest_arch_idx;
  logic            inst_dest_valid;
  logic            rename_stall, rat_allocate_new_prf;
  logic            prf_rename_valid_in;
  logic [W-1:0]    prf_rename_idx_in;
  logic            rename_out_valid;
  logic [W-1:0]    opa_prf_idx, opb_prf_idx, dest_prf_idx;
  logic            branch_mistaken;
  logic [ARCH*W-1:0] rrat_arch_table;
  logic [PRF-1:0]  rat_prf_free_list;
  logic            rat_free_list_valid;

  always #5 clock = ~clock;

  rat_rename_stage dut (
    .clock(clock), .reset(reset), .inst_valid(inst_valid),
    .inst_opa_arch_idx(inst_opa_arch_idx), .inst_opb_arch_idx(inst_opb_arch_idx),
    .inst_dest_arch_idx(inst_dest_arch_idx), .inst_dest_valid(inst_dest_valid),
    .rename_stall(rename_stall), .rat_allocate_new_prf(rat_allocate_new_prf),
    .prf_rename_valid_in(prf_rename_valid_in), .prf_rename_idx_in(prf_rename_idx_in),
    .rename_out_valid(rename_out_valid), .opa_prf_idx(opa_prf_idx),
    .opb_prf_idx(opb_prf_idx), .dest_prf_idx(dest_prf_idx),
    .branch_mistaken(branch_mistaken), .rrat_arch_table(rrat_arch_table),
    .rat_prf_free_list(rat_prf_free_list), .rat_free_list_valid(rat_free_list_valid)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: architectural map as plain integers plus a recovery flag.
  int          mm [ARCH];
  int          rrat_m [ARCH];
  bit          m_recover;
  bit          e_out_vld, e_fl_vld;
  int          e_opa, e_opb, e_dest;
  logic [PRF-1:0] e_fl;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit zero_reg(input int r);
`ifdef RAT_ZERO_REG_EN
    return r == 31;
`else
    return 1'b0;
`endif
  endfunction

  task automatic load_rrat_identity();
    for (int i = 0; i < ARCH; i++) begin
      rrat_m[i] = i;
      rrat_arch_table[i*W +: W] = W'(i);
    end
  endtask

  task automatic load_rrat_random();
    for (int i = 0; i < ARCH; i++) begin
      rrat_m[i] = int'($urandom_range(PRF-1));
      rrat_arch_table[i*W +: W] = W'(rrat_m[i]);
    end
  endtask

  // One clock: drive, check handshake mid-cycle, advance model, check registered outputs.
  task automatic cycle(input bit iv, input int a, input int b, input int d, input bit dv,
                       input bit gv, input int gi, input bit bm, input bit rst_n);
    bit e_alloc, e_stall, accept;
    inst_valid = iv; inst_opa_arch_idx = 5'(a); inst_opb_arch_idx = 5'(b);
    inst_dest_arch_idx = 5'(d); inst_dest_valid = dv;
    prf_rename_valid_in = gv; prf_rename_idx_in = W'(gi);
    branch_mistaken = bm; reset = rst_n;
    @(negedge clock);
    e_alloc = !bm && !m_recover && iv && dv && !zero_reg(d);
    e_stall = bm || m_recover || (e_alloc && !gv);
    chk("alloc_req", 64'(rat_allocate_new_prf), 64'(e_alloc));
    chk("stall", 64'(rename_stall), 64'(e_stall));
    @(posedge clock);
    #1;
    if (!rst_n) begin
      for (int i = 0; i < ARCH; i++) mm[i] = i;
      m_recover = 0; e_out_vld = 0; e_fl_vld = 0;
      e_opa = 0; e_opb = 0; e_dest = 0; e_fl = '0;
      chk("rst_opa", 64'(opa_prf_idx), 0);
      chk("rst_opb", 64'(opb_prf_idx), 0);
      chk("rst_dest", 64'(dest_prf_idx), 0);
      chk("rst_fl", 64'(rat_prf_free_list), 0);
    end else if (bm) begin
      e_fl = '0;
      for (int i = 0; i < ARCH; i++) if (!zero_reg(i)) e_fl[mm[i]] = 1'b1;
      for (int i = 0; i < ARCH; i++) if (!zero_reg(i)) mm[i] = rrat_m[i];
      e_fl_vld = 1; e_out_vld = 0; m_recover = 1;
    end else begin
      m_recover = 0;
      e_fl_vld = 0;
      accept = iv && !e_stall;
      e_out_vld = accept;
      if (accept) begin
        e_opa = mm[a]; e_opb = mm[b];
        e_dest = e_alloc ? gi : 0;
        if (e_alloc) mm[d] = gi;
      end
    end
    chk("out_valid", 64'(rename_out_valid), 64'(e_out_vld));
    chk("fl_valid", 64'(rat_free_list_valid), 64'(e_fl_vld));
    if (e_out_vld) begin
      chk("opa", 64'(opa_prf_idx), 64'(e_opa));
      chk("opb", 64'(opb_prf_idx), 64'(e_opb));
      chk("dest", 64'(dest_prf_idx), 64'(e_dest));
    end
    if (e_fl_vld) chk("free_list", 64'(rat_prf_free_list), 64'(e_fl));
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    logic [PRF-1:0] fl_snap;
    load_rrat_identity();
    m_recover = 0;
    for (int i = 0; i < ARCH; i++) mm[i] = i;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_out_valid", 64'(rename_out_valid), 0);

    // Basic rename and dependent lookup.
    cycle(1, 1, 2, 3, 1, 1, 40, 0, 1);
    chk("tp1_opa", 64'(opa_prf_idx), 1);
    chk("tp1_opb", 64'(opb_prf_idx), 2);
    chk("tp1_dest", 64'(dest_prf_idx), 40);
    cycle(1, 3, 0, 4, 1, 1, 41, 0, 1);
    chk("tp1_dep_opa", 64'(opa_prf_idx), 40);

    // Source equals destination returns the old mapping.
    cycle(1, 5, 5, 5, 1, 1, 43, 0, 1);
    chk("tp2_opa_old", 64'(opa_prf_idx), 5);
    chk("tp2_dest", 64'(dest_prf_idx), 43);
    cycle(1, 5, 0, 0, 0, 0, 0, 0, 1);
    chk("tp2_map5", 64'(opa_prf_idx), 43);

    // Missing grant stalls, then is accepted.
    cycle(1, 6, 7, 8, 1, 0, 0, 0, 1);
    chk("tp3_stall_vld0", 64'(rename_out_valid), 0);
    cycle(1, 6, 7, 8, 1, 0, 0, 0, 1);
    cycle(1, 6, 7, 8, 1, 1, 42, 0, 1);
    chk("tp3_dest", 64'(dest_prf_idx), 42);

    // Mispredict with identity RRAT; r3->40, r4->41 must appear in the free list.
    load_rrat_identity();
    cycle(1, 1, 1, 9, 1, 1, 44, 1, 1);
    fl_snap = rat_prf_free_list;
    chk("tp4_bit40", 64'(fl_snap[40]), 1);
    chk("tp4_bit41", 64'(fl_snap[41]), 1);
    chk("tp4_bit3", 64'(fl_snap[3]), 0);
    chk("tp4_bit4", 64'(fl_snap[4]), 0);
    cycle(1, 3, 4, 0, 0, 0, 0, 0, 1);
    chk("tp4_recover_stall", 64'(rename_out_valid), 0);
    cycle(1, 3, 4, 0, 0, 0, 0, 0, 1);
    chk("tp4_opa_restored", 64'(opa_prf_idx), 3);

    // Register 31 as destination.
    cycle(1, 0, 0, 31, 1, 1, 50, 0, 1);
    cycle(1, 31, 0, 0, 0, 0, 0, 0, 1);
`ifdef RAT_ZERO_REG_EN
    chk("tp5_map31", 64'(opa_prf_idx), 31);
`else
    chk("tp5_map31", 64'(opa_prf_idx), 50);
`endif

    // Reset in the middle of recovery.
    cycle(1, 2, 3, 12, 1, 1, 55, 0, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("tp6_fl_valid", 64'(rat_free_list_valid), 0);
    cycle(1, 12, 0, 0, 0, 0, 0, 0, 1);
    chk("tp6_identity", 64'(opa_prf_idx), 12);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      bit bm, rst_n;
      bm = ($urandom_range(99) < 6);
      rst_n = ($urandom_range(199) != 0);
      if (bm) load_rrat_random();
      cycle($urandom_range(3) != 0, int'($urandom_range(31)), int'($urandom_range(31)),
            int'($urandom_range(31)), $urandom_range(3) != 0, $urandom_range(9) < 7,
            int'($urandom_range(PRF-1)), bm, rst_n);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
